// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the program-counter sequencing controller.
package pc_seq_pkg;

  localparam int unsigned STALL_W_DEF = 3;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } pc_seq_state_t;

endpackage

// File: rtl/stall_timer.sv
// Down-counter holding the remaining extra cycles of a multi-cycle instruction.
module stall_timer #(
  parameter int unsigned W = 3
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/pc_seq_ctrl.sv
// PC sequencing FSM (IDLE/RUN/STALL/HALT) with optional performance counters.
// Define PERF_CNT_EN to build the CycCnt/StallCnt counters; otherwise they read 0.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter int unsigned STALL_W = STALL_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Halt,
  input  logic               Resume,
  input  logic               MultiCyc,
  input  logic [STALL_W-1:0] StallLen,
  input  logic               Jen,
  input  logic               Zero,
  output logic               PcRst,
  output logic               PcEn,
  output logic               PcLoad,
  output logic               Busy,
  output logic               Halted,
  output logic [CNT_W-1:0]   CycCnt,
  output logic [CNT_W-1:0]   StallCnt
);

  pc_seq_state_t state;
  pc_seq_state_t state_nxt;
  logic          timer_load;
  logic          timer_dec;
  logic          timer_last;

  stall_timer #(
    .W (STALL_W)
  ) u_stall_timer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (timer_load),
    .load_val (StallLen),
    .dec      (timer_dec),
    .last     (timer_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and zero-latency PC controls; Halt outranks MultiCyc in RUN.
  always_comb begin
    state_nxt  = state;
    PcRst      = 1'b0;
    PcEn       = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        PcRst = 1'b1;
        if (Start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          state_nxt = ST_HALT;
        end else if (MultiCyc && (StallLen != '0)) begin
          timer_load = 1'b1;
          state_nxt  = ST_STALL;
        end else begin
          PcEn = 1'b1;
        end
      end
      ST_STALL: begin
        timer_dec = 1'b1;
        if (timer_last) begin
          PcEn      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        if (Resume) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign PcLoad = PcEn & Jen & Zero;
  assign Busy   = (state == ST_RUN) || (state == ST_STALL);
  assign Halted = (state == ST_HALT);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] stl_q;

  // Saturating activity counters, cleared when a new run is started.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else if ((state == ST_IDLE) && Start) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else begin
      if (Busy && (cyc_q != '1)) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if ((state == ST_STALL) && (stl_q != '1)) begin
        stl_q <= stl_q + CNT_W'(1);
      end
    end
  end

  assign CycCnt   = cyc_q;
  assign StallCnt = stl_q;
`else
  assign CycCnt   = '0;
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: vector table through a scoreboard plus reset/long-run sequences.
module tb_pc_seq_ctrl;

  localparam int unsigned STALL_W = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic               start;
    logic               halt;
    logic               resume;
    logic               mc;
    logic [STALL_W-1:0] len;
    logic               jen;
    logic               zero;
    logic               e_rst;
    logic               e_en;
    logic               e_ld;
    logic               e_busy;
    logic               e_halted;
    logic               e_stl;
  } vec_t;

  typedef struct {
    logic e_rst;
    logic e_en;
    logic e_ld;
    logic e_busy;
    logic e_halted;
    int   cyc;
    int   stl;
  } exp_t;

  logic               Clk;
  logic               Reset_n;
  logic               Start;
  logic               Halt;
  logic               Resume;
  logic               MultiCyc;
  logic [STALL_W-1:0] StallLen;
  logic               Jen;
  logic               Zero;
  logic               PcRst;
  logic               PcEn;
  logic               PcLoad;
  logic               Busy;
  logic               Halted;
  logic [CNT_W-1:0]   CycCnt;
  logic [CNT_W-1:0]   StallCnt;

  int   total = 0;
  int   bad   = 0;
  int   m_cyc = 0;
  int   m_stl = 0;
  vec_t vt[$];
  exp_t sb[$];

  pc_seq_ctrl #(
    .STALL_W (STALL_W),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Halt     (Halt),
    .Resume   (Resume),
    .MultiCyc (MultiCyc),
    .StallLen (StallLen),
    .Jen      (Jen),
    .Zero     (Zero),
    .PcRst    (PcRst),
    .PcEn     (PcEn),
    .PcLoad   (PcLoad),
    .Busy     (Busy),
    .Halted   (Halted),
    .CycCnt   (CycCnt),
    .StallCnt (StallCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int cnt_exp(input int v);
`ifdef PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? v : v + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic h, input logic r, input logic mc,
                     input int len, input logic j, input logic z,
                     input logic ers, input logic een, input logic eld,
                     input logic ebusy, input logic ehalt, input logic estl);
    vec_t v;
    v.start = st;  v.halt = h;  v.resume = r;  v.mc = mc;
    v.len = STALL_W'(len);  v.jen = j;  v.zero = z;
    v.e_rst = ers;  v.e_en = een;  v.e_ld = eld;
    v.e_busy = ebusy;  v.e_halted = ehalt;  v.e_stl = estl;
    vt.push_back(v);
  endtask

  task automatic drive(input logic st, input logic h, input logic r, input logic mc,
                       input logic [STALL_W-1:0] len, input logic j, input logic z);
    Start = st;  Halt = h;  Resume = r;  MultiCyc = mc;
    StallLen = len;  Jen = j;  Zero = z;
  endtask

  task automatic check_sb(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_PcRst"},    int'(PcRst),    int'(e.e_rst));
      chk({tag, "_PcEn"},     int'(PcEn),     int'(e.e_en));
      chk({tag, "_PcLoad"},   int'(PcLoad),   int'(e.e_ld));
      chk({tag, "_Busy"},     int'(Busy),     int'(e.e_busy));
      chk({tag, "_Halted"},   int'(Halted),   int'(e.e_halted));
      chk({tag, "_CycCnt"},   int'(CycCnt),   e.cyc);
      chk({tag, "_StallCnt"}, int'(StallCnt), e.stl);
    end
  endtask

  initial begin
    exp_t e;
    Reset_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0);

    // st h r mc len j z | rst en ld busy halted stall
    add(0,0,0,0,0,0,0, 1,0,0,0,0,0);  // IDLE waits
    add(1,0,0,0,0,0,0, 1,0,0,0,0,0);  // IDLE accepts Start
    add(0,0,0,0,0,0,0, 0,1,0,1,0,0);  // RUN increments
    add(0,0,0,0,0,1,1, 0,1,1,1,0,0);  // taken jump
    add(0,0,0,0,0,1,0, 0,1,0,1,0,0);  // not taken
    add(1,0,0,0,0,0,0, 0,1,0,1,0,0);  // Start ignored in RUN
    add(0,0,0,1,3,0,0, 0,0,0,1,0,0);  // enter 3-cycle stall
    add(0,1,0,1,0,0,0, 0,0,0,1,0,1);  // Halt/MultiCyc ignored in STALL
    add(0,0,0,0,0,1,1, 0,0,0,1,0,1);  // no PcLoad while PcEn=0
    add(0,0,0,0,0,0,0, 0,1,0,1,0,1);  // last stall cycle
    add(0,0,0,1,0,0,0, 0,1,0,1,0,0);  // MultiCyc with len 0: no stall
    add(0,0,0,1,2,0,0, 0,0,0,1,0,0);  // enter 2-cycle stall
    add(0,0,0,0,0,1,1, 0,0,0,1,0,1);
    add(0,0,0,0,0,1,1, 0,1,1,1,0,1);  // jump on last stall cycle
    add(0,1,0,1,3,0,0, 0,0,0,1,0,0);  // Halt beats MultiCyc
    add(1,0,0,0,0,1,1, 0,0,0,0,1,0);  // HALT ignores Start
    add(0,0,1,0,0,0,0, 0,0,0,0,1,0);  // Resume
    add(0,0,0,0,0,0,0, 0,1,0,1,0,0);
    add(0,0,0,1,1,0,0, 0,0,0,1,0,0);  // 1-cycle stall
    add(0,0,0,0,0,0,0, 0,1,0,1,0,1);
    add(0,0,0,0,0,0,0, 0,1,0,1,0,0);

    // reset values, checked asynchronously before any clock edge
    #2;
    chk("rst_PcRst", int'(PcRst), 1);
    chk("rst_PcEn", int'(PcEn), 0);
    chk("rst_Busy", int'(Busy), 0);
    chk("rst_Halted", int'(Halted), 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    foreach (vt[i]) begin
      drive(vt[i].start, vt[i].halt, vt[i].resume, vt[i].mc, vt[i].len, vt[i].jen, vt[i].zero);
      e.e_rst = vt[i].e_rst;  e.e_en = vt[i].e_en;  e.e_ld = vt[i].e_ld;
      e.e_busy = vt[i].e_busy;  e.e_halted = vt[i].e_halted;
      e.cyc = cnt_exp(m_cyc);  e.stl = cnt_exp(m_stl);
      sb.push_back(e);
      @(negedge Clk);
      check_sb($sformatf("vec%0d", i));
      @(posedge Clk);
      #1;
      if (vt[i].e_rst && vt[i].start) begin
        m_cyc = 0;
        m_stl = 0;
      end else begin
        if (vt[i].e_busy) m_cyc = sat_inc(m_cyc);
        if (vt[i].e_stl)  m_stl = sat_inc(m_stl);
      end
    end

    // reset asserted in the second cycle of a stall aborts it
    drive(0, 0, 0, 1, 3'd3, 0, 0);
    @(posedge Clk);
    #1 drive(0, 0, 0, 0, '0, 0, 0);
    @(negedge Clk);
    chk("stall1_PcEn", int'(PcEn), 0);
    chk("stall1_Busy", int'(Busy), 1);
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("midrst_PcRst", int'(PcRst), 1);
    chk("midrst_PcEn", int'(PcEn), 0);
    chk("midrst_Busy", int'(Busy), 0);
    chk("midrst_CycCnt", int'(CycCnt), 0);
    chk("midrst_StallCnt", int'(StallCnt), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk($sformatf("post_rst%0d_PcRst", k), int'(PcRst), 1);
      chk($sformatf("post_rst%0d_Busy", k), int'(Busy), 0);
      chk($sformatf("post_rst%0d_PcEn", k), int'(PcEn), 0);
    end

    // long run: counters saturate (or stay 0), PcEn every cycle, random jumps
    @(posedge Clk);
    #1 drive(1, 0, 0, 0, '0, 0, 0);
    @(posedge Clk);
    #1;
    m_cyc = 0;
    m_stl = 0;
    for (int k = 0; k < 100; k++) begin
      logic j;
      logic z;
      j = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 1)), 0, 0, 0, '0, j, z);
      e.e_rst = 0;  e.e_en = 1;  e.e_ld = j & z;  e.e_busy = 1;  e.e_halted = 0;
      e.cyc = cnt_exp(m_cyc);  e.stl = cnt_exp(m_stl);
      sb.push_back(e);
      @(negedge Clk);
      check_sb($sformatf("run%0d", k));
      @(posedge Clk);
      #1;
      m_cyc = sat_inc(m_cyc);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
